// File: rtl/arc4_ctrl_if.sv
// Bus bundle between the ARC4 sequencer and its surroundings: top-level start/done,
// the three stage handshakes, the stage S-memory ports and the muxed S-memory port.
interface arc4_ctrl_if #(
  parameter int KEY_W  = 24,
  parameter int ADDR_W = 8
);
  logic              en;
  logic              rdy;
  logic [KEY_W-1:0]  key;
  logic [KEY_W-1:0]  key_out;

  logic              init_en,     ksa_en,     prga_en;
  logic              init_rdy,    ksa_rdy,    prga_rdy;
  logic [ADDR_W-1:0] init_addr,   ksa_addr,   prga_addr;
  logic [7:0]        init_wrdata, ksa_wrdata, prga_wrdata;
  logic              init_wren,   ksa_wren,   prga_wren;

  logic [ADDR_W-1:0] s_addr;
  logic [7:0]        s_wrdata;
  logic              s_wren;

  logic [1:0]        stage;
  logic              err;
  logic [31:0]       cycles;

  // The controller sits on the slave side; whoever drives start and the stages is master.
  modport slave (
    input  en, key,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output rdy, key_out,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren,
    output stage, err, cycles
  );

  modport master (
    output en, key,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  rdy, key_out,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren,
    input  stage, err, cycles
  );
endinterface

// File: rtl/arc4_ctrl.sv
// ARC4 top-level sequencer: runs init -> ksa -> prga and owns the S-memory write port.
// Optional run-length counter on cycles is enabled by defining ARC4_CYCLE_COUNT_EN.
module arc4_ctrl #(
  parameter int KEY_W  = 24,
  parameter int ADDR_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  arc4_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    INIT_GO,
    INIT_WAIT,
    KSA_GO,
    KSA_WAIT,
    PRGA_GO,
    PRGA_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              busy_seen_q, busy_seen_d;
  logic [KEY_W-1:0]  key_out_q, key_out_d;
  logic              err_q, err_d;

  logic              accept;
  logic              init_en_c, ksa_en_c, prga_en_c;
  logic [1:0]        stage_c;
  logic              nonowner_wr;
  logic [ADDR_W-1:0] s_addr_c;
  logic [7:0]        s_wrdata_c;
  logic              s_wren_c;

  assign accept = (state_q == IDLE) && bus.en;

  always_comb begin
    state_d     = state_q;
    busy_seen_d = busy_seen_q;
    init_en_c   = 1'b0;
    ksa_en_c    = 1'b0;
    prga_en_c   = 1'b0;
    stage_c     = 2'd0;
    case (state_q)
      IDLE: begin
        if (bus.en) state_d = INIT_GO;
      end
      INIT_GO: begin
        stage_c = 2'd1;
        if (bus.init_rdy) begin
          init_en_c   = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = INIT_WAIT;
        end
      end
      // A stage is finished only after it has been seen busy and then idle again.
      INIT_WAIT: begin
        stage_c = 2'd1;
        if (!bus.init_rdy)      busy_seen_d = 1'b1;
        else if (busy_seen_q)   state_d     = KSA_GO;
      end
      KSA_GO: begin
        stage_c = 2'd2;
        if (bus.ksa_rdy) begin
          ksa_en_c    = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = KSA_WAIT;
        end
      end
      KSA_WAIT: begin
        stage_c = 2'd2;
        if (!bus.ksa_rdy)       busy_seen_d = 1'b1;
        else if (busy_seen_q)   state_d     = PRGA_GO;
      end
      PRGA_GO: begin
        stage_c = 2'd3;
        if (bus.prga_rdy) begin
          prga_en_c   = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = PRGA_WAIT;
        end
      end
      PRGA_WAIT: begin
        stage_c = 2'd3;
        if (!bus.prga_rdy)      busy_seen_d = 1'b1;
        else if (busy_seen_q)   state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_addr_c   = '0;
    s_wrdata_c = '0;
    s_wren_c   = 1'b0;
    case (stage_c)
      2'd1: begin
        s_addr_c   = bus.init_addr;
        s_wrdata_c = bus.init_wrdata;
        s_wren_c   = bus.init_wren;
      end
      2'd2: begin
        s_addr_c   = bus.ksa_addr;
        s_wrdata_c = bus.ksa_wrdata;
        s_wren_c   = bus.ksa_wren;
      end
      2'd3: begin
        s_addr_c   = bus.prga_addr;
        s_wrdata_c = bus.prga_wrdata;
        s_wren_c   = bus.prga_wren;
      end
      default: ;
    endcase
  end

  assign nonowner_wr = (bus.init_wren && (stage_c != 2'd1)) ||
                       (bus.ksa_wren  && (stage_c != 2'd2)) ||
                       (bus.prga_wren && (stage_c != 2'd3));

  always_comb begin
    key_out_d = key_out_q;
    err_d     = err_q;
    if (accept)      key_out_d = bus.key;
    if (nonowner_wr) err_d     = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_seen_q <= 1'b0;
      key_out_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_seen_q <= busy_seen_d;
      key_out_q   <= key_out_d;
      err_q       <= err_d;
    end
  end

`ifdef ARC4_CYCLE_COUNT_EN
  logic [31:0] cycles_q, cycles_d;

  // Cleared on acceptance, counts every non-idle edge, sticks at all-ones.
  always_comb begin
    cycles_d = cycles_q;
    if (accept)                                          cycles_d = '0;
    else if ((state_q != IDLE) && (cycles_q != '1))      cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycles_q <= '0;
    else     cycles_q <= cycles_d;
  end

  assign bus.cycles = cycles_q;
`else
  assign bus.cycles = '0;
`endif

  assign bus.rdy      = (state_q == IDLE);
  assign bus.key_out  = key_out_q;
  assign bus.init_en  = init_en_c;
  assign bus.ksa_en   = ksa_en_c;
  assign bus.prga_en  = prga_en_c;
  assign bus.stage    = stage_c;
  assign bus.err      = err_q;
  assign bus.s_addr   = s_addr_c;
  assign bus.s_wrdata = s_wrdata_c;
  assign bus.s_wren   = s_wren_c;

endmodule

// File: tb/tb_arc4_ctrl.sv
// Directed bench for arc4_ctrl with behavioural init/ksa/prga stage models.
module tb_arc4_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arc4_ctrl_if #(.KEY_W(24), .ADDR_W(8)) bus ();

  arc4_ctrl #(.KEY_W(24), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int init_len  = 256;
  int ksa_len   = 1536;
  int prga_len  = 100;
  int stall_req = 0;

  // Stage models: drop rdy the cycle after en, stay busy for <len> cycles.
  initial begin
    bus.init_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.init_en) begin
        @(posedge clk); #1 bus.init_rdy = 1'b0;
        repeat (init_len) @(posedge clk);
        #1 bus.init_rdy = 1'b1;
      end
    end
  end

  initial begin
    int served;
    int cnt;
    served = 0;
    cnt    = 0;
    bus.ksa_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.ksa_en) begin
        @(posedge clk); #1 bus.ksa_rdy = 1'b0;
        repeat (ksa_len) @(posedge clk);
        #1 bus.ksa_rdy = 1'b1;
      end else if ((stall_req != served) && bus.ksa_rdy) begin
        cnt = 0;
        @(posedge clk); #1 bus.ksa_rdy = 1'b0;
      end else if ((stall_req != served) && (bus.stage == 2'd2)) begin
        cnt++;
        if (cnt == 5) begin
          served++;
          @(posedge clk); #1 bus.ksa_rdy = 1'b1;
        end
      end
    end
  end

  initial begin
    bus.prga_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.prga_en) begin
        @(posedge clk); #1 bus.prga_rdy = 1'b0;
        repeat (prga_len) @(posedge clk);
        #1 bus.prga_rdy = 1'b1;
      end
    end
  end

  task automatic start_run(input logic [23:0] k);
    @(negedge clk);
    bus.key = k;
    bus.en  = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while ((n < budget) && !ok) begin
      @(posedge clk);
      n++;
      #1 if (bus.rdy) ok = 1'b1;
    end
  endtask

  task automatic wait_stage_wait(input logic [1:0] st, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while ((n < 500) && !ok) begin
      @(negedge clk);
      n++;
      if ((bus.stage == st) && !bus.init_en && !bus.ksa_en && !bus.prga_en &&
          (((st == 2'd2) && !bus.ksa_rdy) || ((st == 2'd3) && !bus.prga_rdy)))
        ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.rdy, bus.stage, bus.s_wren, bus.init_en, bus.ksa_en, bus.prga_en, bus.err} !== 8'b1_00_0_0_0_0_0) begin
      n_bad++;
      $display("FAIL reset_hold_flags: got %b want 10000000",
               {bus.rdy, bus.stage, bus.s_wren, bus.init_en, bus.ksa_en, bus.prga_en, bus.err});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({bus.rdy, bus.stage, bus.s_wren, bus.init_en, bus.ksa_en, bus.prga_en, bus.err} !== 8'b1_00_0_0_0_0_0) begin
      n_bad++;
      $display("FAIL idle_flags: got %b want 10000000",
               {bus.rdy, bus.stage, bus.s_wren, bus.init_en, bus.ksa_en, bus.prga_en, bus.err});
    end
    n_cmp++;
    if ({bus.key_out, bus.s_addr, bus.s_wrdata} !== 40'h0) begin
      n_bad++;
      $display("FAIL idle_data: got %h want 0", {bus.key_out, bus.s_addr, bus.s_wrdata});
    end
    n_cmp++;
    if (bus.cycles !== 32'd0) begin
      n_bad++;
      $display("FAIL idle_cycles: got %0d want 0", bus.cycles);
    end
  endtask

  task automatic test_full_run;
    int  n, ci, ck, cp;
    bit  ok, order_ok, key_ok;
    init_len = 256; ksa_len = 1536; prga_len = 100;
    n = 0; ci = 0; ck = 0; cp = 0;
    ok = 1'b0; order_ok = 1'b1; key_ok = 1'b1;
    start_run(24'h00033C);
    while ((n < 5000) && !ok) begin
      @(negedge clk);
      if (bus.init_en) begin ci++; if ((ck != 0) || (cp != 0)) order_ok = 1'b0; end
      if (bus.ksa_en)  begin ck++; if ((ci != 1) || (cp != 0)) order_ok = 1'b0; end
      if (bus.prga_en) begin cp++; if ((ci != 1) || (ck != 1)) order_ok = 1'b0; end
      if (bus.key_out !== 24'h00033C) key_ok = 1'b0;
      @(posedge clk);
      n++;
      #1 if (bus.rdy) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL full_run_timeout: rdy not back after %0d cycles", n); end
    n_cmp++;
    if ({ci, ck, cp} !== {32'd1, 32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL full_run_pulses: got init=%0d ksa=%0d prga=%0d want 1/1/1", ci, ck, cp);
    end
    n_cmp++;
    if (!order_ok) begin n_bad++; $display("FAIL full_run_order: got out-of-order en pulses want init,ksa,prga"); end
    n_cmp++;
    if (!key_ok) begin n_bad++; $display("FAIL full_run_key: key_out left 00033c during run"); end
    n_cmp++;
    if (n !== 1898) begin n_bad++; $display("FAIL full_run_length: got %0d cycles want 1898", n); end
    n_cmp++;
`ifdef ARC4_CYCLE_COUNT_EN
    if (bus.cycles !== n) begin n_bad++; $display("FAIL full_run_cycles: got %0d want %0d", bus.cycles, n); end
`else
    if (bus.cycles !== 32'd0) begin n_bad++; $display("FAIL full_run_cycles: got %0d want 0", bus.cycles); end
`endif
    n_cmp++;
    if ({bus.key_out, bus.stage, bus.err} !== {24'h00033C, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL full_run_end: got key=%h stage=%0d err=%b want 00033c/0/0", bus.key_out, bus.stage, bus.err);
    end
  endtask

  task automatic test_mux_ownership;
    int n;
    bit ok;
    init_len = 4; ksa_len = 20; prga_len = 4;
    start_run(24'hABCDEF);
    wait_stage_wait(2'd2, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mux_reach_ksa_wait: got timeout want KSA_WAIT"); end
    bus.ksa_addr = 8'h2A; bus.ksa_wrdata = 8'h5C; bus.ksa_wren = 1'b1;
    #1;
    n_cmp++;
    if ({bus.s_addr, bus.s_wrdata, bus.s_wren, bus.stage} !== {8'h2A, 8'h5C, 1'b1, 2'd2}) begin
      n_bad++;
      $display("FAIL mux_ksa_owner: got addr=%h data=%h wren=%b stage=%0d want 2a/5c/1/2",
               bus.s_addr, bus.s_wrdata, bus.s_wren, bus.stage);
    end
    bus.init_wren = 1'b1; bus.init_addr = 8'h11; bus.init_wrdata = 8'h99;
    #1;
    n_cmp++;
    if ({bus.s_addr, bus.s_wrdata, bus.s_wren, bus.err} !== {8'h2A, 8'h5C, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL mux_nonowner_same_cycle: got addr=%h data=%h wren=%b err=%b want 2a/5c/1/0",
               bus.s_addr, bus.s_wrdata, bus.s_wren, bus.err);
    end
    bus.ksa_wren = 1'b0;
    #1;
    n_cmp++;
    if (bus.s_wren !== 1'b0) begin
      n_bad++;
      $display("FAIL mux_nonowner_not_forwarded: got s_wren=%b want 0", bus.s_wren);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", bus.err); end
    @(negedge clk);
    bus.init_wren = 1'b0; bus.ksa_addr = 8'h00; bus.ksa_wrdata = 8'h00;
    wait_done(500, n, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mux_run_timeout: got no rdy after %0d cycles", n); end
    n_cmp++;
    if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", bus.err); end
  endtask

  task automatic test_stage_not_ready;
    int n;
    bit ok;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    init_len = 4; ksa_len = 6; prga_len = 4;
    stall_req = stall_req + 1;
    repeat (3) @(negedge clk);
    start_run(24'h0A0B0C);
    n = 0;
    ok = 1'b0;
    while ((n < 200) && !ok) begin
      @(negedge clk);
      n++;
      if (bus.stage == 2'd2) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL stall_reach_ksa: got timeout want stage 2"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if ({bus.ksa_en, bus.stage} !== {1'b0, 2'd2}) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got ksa_en=%b stage=%0d want 0/2", i, bus.ksa_en, bus.stage);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ksa_en !== 1'b1) begin n_bad++; $display("FAIL stall_release_pulse: got %b want 1", bus.ksa_en); end
    @(negedge clk);
    n_cmp++;
    if ({bus.ksa_en, bus.stage} !== {1'b0, 2'd2}) begin
      n_bad++;
      $display("FAIL stall_single_pulse: got ksa_en=%b stage=%0d want 0/2", bus.ksa_en, bus.stage);
    end
    wait_done(500, n, ok);
    n_cmp++;
    if (!ok || (bus.err !== 1'b0)) begin
      n_bad++;
      $display("FAIL stall_run_end: got rdy_ok=%b err=%b want 1/0", ok, bus.err);
    end
  endtask

  task automatic test_abort;
    int n;
    bit ok;
    init_len = 4; ksa_len = 4; prga_len = 100;
    start_run(24'h0F0F0F);
    wait_stage_wait(2'd3, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL abort_reach_prga_wait: got timeout want PRGA_WAIT"); end
    repeat (10) @(negedge clk);
    bus.prga_addr = 8'h77; bus.prga_wrdata = 8'hE1; bus.prga_wren = 1'b1;
    #1;
    n_cmp++;
    if ({bus.s_addr, bus.s_wrdata, bus.s_wren, bus.stage} !== {8'h77, 8'hE1, 1'b1, 2'd3}) begin
      n_bad++;
      $display("FAIL mux_prga_owner: got addr=%h data=%h wren=%b stage=%0d want 77/e1/1/3",
               bus.s_addr, bus.s_wrdata, bus.s_wren, bus.stage);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.rdy, bus.stage, bus.s_wren, bus.init_en, bus.ksa_en, bus.prga_en, bus.err} !== 8'b1_00_0_0_0_0_0) begin
      n_bad++;
      $display("FAIL abort_flags: got %b want 10000000",
               {bus.rdy, bus.stage, bus.s_wren, bus.init_en, bus.ksa_en, bus.prga_en, bus.err});
    end
    n_cmp++;
    if ({bus.key_out, bus.s_addr, bus.s_wrdata, bus.cycles} !== 72'h0) begin
      n_bad++;
      $display("FAIL abort_data: got key=%h addr=%h data=%h cycles=%0d want all 0",
               bus.key_out, bus.s_addr, bus.s_wrdata, bus.cycles);
    end
    bus.prga_wren = 1'b0; bus.prga_addr = 8'h00; bus.prga_wrdata = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while ((n < 300) && !bus.prga_rdy) begin
      @(negedge clk);
      n++;
    end
    prga_len = 4;
    start_run(24'h123456);
    n_cmp++;
    if ({bus.key_out, bus.rdy, bus.stage} !== {24'h123456, 1'b0, 2'd1}) begin
      n_bad++;
      $display("FAIL restart_accept: got key=%h rdy=%b stage=%0d want 123456/0/1",
               bus.key_out, bus.rdy, bus.stage);
    end
    wait_done(500, n, ok);
    n_cmp++;
    if (!ok || (bus.key_out !== 24'h123456)) begin
      n_bad++;
      $display("FAIL restart_run: got rdy_ok=%b key=%h want 1/123456", ok, bus.key_out);
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.key = '0;
    bus.init_addr = '0; bus.init_wrdata = '0; bus.init_wren = 1'b0;
    bus.ksa_addr  = '0; bus.ksa_wrdata  = '0; bus.ksa_wren  = 1'b0;
    bus.prga_addr = '0; bus.prga_wrdata = '0; bus.prga_wren = 1'b0;
    test_reset;
    test_full_run;
    test_mux_ownership;
    test_stage_not_ready;
    test_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arc4_ctrl.md
Name: arc4_ctrl

Overview:
- Top-level sequencer for the ARC4 datapath.
- Owns the single-port 256x8 S memory and runs init, ksa and prga in order, using each sub-block's en/rdy handshake.
- Multiplexes the active stage's write/address port onto the S memory and latches the key for the run.
- Sits between the top-level start/done handshake and the three stage blocks.

Parameters:
KEY_W, 24, key width in bits, forwarded unchanged to ksa.
ADDR_W, 8, S memory address width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  start request; sampled only while rdy=1
rdy  output  1  controller idle, will accept en
key  input  KEY_W  key, captured on en&&rdy
key_out  output  KEY_W  latched key to ksa/prga
init_en, ksa_en, prga_en  output  1 each  one-cycle start pulse to a stage
init_rdy, ksa_rdy, prga_rdy  input  1 each  stage idle/done
init_addr, ksa_addr, prga_addr  input  ADDR_W each  stage S address
init_wrdata, ksa_wrdata, prga_wrdata  input  8 each  stage S write data
init_wren, ksa_wren, prga_wren  input  1 each  stage S write enable
s_addr  output  ADDR_W  to S memory
s_wrdata  output  8  to S memory
s_wren  output  1  to S memory
stage  output  2  current owner: 0 none, 1 init, 2 ksa, 3 prga
err  output  1  sticky: a non-owner asserted wren
cycles  output  32  run length (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE, key_out=0, err=0, cycles=0, busy_seen=0. Resulting outputs: rdy=1, all *_en=0, s_wren=0, s_addr=0, s_wrdata=0, stage=0.
- States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT.
- IDLE: rdy=1.
  - en=1 at an edge: latch key into key_out, go to INIT_GO.
  - en=0: stay in IDLE.
- X_GO (X = init/ksa/prga):
  - x_en = (state==X_GO) && x_rdy, combinational.
  - If x_rdy=1: go to X_WAIT on that edge, clear busy_seen. Exactly one x_en cycle per stage.
  - If x_rdy=0: hold in X_GO; no pulse.
- X_WAIT:
  - Set busy_seen when x_rdy=0.
  - Leave when busy_seen=1 and x_rdy=1: INIT_WAIT->KSA_GO, KSA_WAIT->PRGA_GO, PRGA_WAIT->IDLE.
  - A stage that never drops rdy hangs the controller in X_WAIT. This is intended; sub-blocks must drop rdy the cycle after en.
- en while rdy=0: ignored; no queuing.
- key_out holds its value from capture until the next accepted en.
- stage is 1 in INIT_*, 2 in KSA_*, 3 in PRGA_*, 0 in IDLE.
- Memory mux (combinational): s_addr, s_wrdata and s_wren come from the stage-selected owner. stage=0 gives all zeros.
- Non-owner wren is never forwarded.
- err is set on the edge where any non-owner x_wren=1. It is cleared only by rst.
- No pipelining: owner outputs reach the memory in the same cycle. Read data fans out to stages outside this block.
- Minimum overhead with stages ready: 1 cycle IDLE->INIT_GO, plus for each stage 1 GO cycle and 1 trailing WAIT cycle after rdy rises.

Optional Feature:
- Macro ARC4_CYCLE_COUNT_EN.
- Defined:
  - cycles clears to 0 on en&&rdy.
  - Increments by 1 every clock while state!=IDLE; saturates at 32'hFFFFFFFF.
  - Holds its value in IDLE until the next accepted en.
- Undefined: cycles is tied to 0 and no counter is synthesised.

Test Plan:
- Reset then idle: rst pulse, en=0 for 10 cycles -> rdy=1, stage=0, s_wren=0, all *_en=0, err=0.
- Full run: key=24'h00033C, en=1 for one cycle. Bench stage models drop rdy the cycle after en and stay busy 256 (init), 1536 (ksa), 100 (prga) cycles. Required response:
  - init_en, ksa_en and prga_en each pulse exactly once, in that order.
  - key_out=24'h00033C throughout.
  - rdy returns to 1.
  - With ARC4_CYCLE_COUNT_EN, cycles equals the measured en-to-rdy cycle count.
- Mux ownership: during KSA_WAIT, ksa drives addr=8'h2A, wrdata=8'h5C, wren=1 -> s_addr=8'h2A, s_wrdata=8'h5C, s_wren=1, stage=2.
- Non-owner write: in the same window, init_wren=1 -> s_wren still follows ksa and err=1 from the next edge, persisting after the run.
- Stage not ready: ksa_rdy=0 held 5 cycles on KSA_GO entry -> ksa_en stays 0, state holds; ksa_en pulses 1 cycle after ksa_rdy rises.
- Abort: rst asserted mid-PRGA_WAIT -> outputs immediately return to reset values. A new en=1 with key=24'h123456 then starts a fresh run with key_out=24'h123456.
